// File: rtl/expr_recognizer_if.sv
// rtl/expr_recognizer_if.sv - symbol input and status output bundle for expr_recognizer
interface expr_recognizer_if #(
  parameter int CNT_W = 8
);
  logic             in_valid;
  logic [7:0]       in;
  logic             out;
  logic             accept;
  logic             error;
  logic [3:0]       depth;
  logic [CNT_W-1:0] operand_cnt;

  modport master (
    output in_valid, in,
    input  out, accept, error, depth, operand_cnt
  );

  modport slave (
    input  in_valid, in,
    output out, accept, error, depth, operand_cnt
  );
endinterface

// File: rtl/expr_recognizer.sv
// rtl/expr_recognizer.sv - streaming recogniser for '=' terminated ASCII arithmetic expressions
module expr_recognizer #(
  parameter int MAX_DIGITS  = 4,
  parameter int MAX_DEPTH   = 7,
  parameter int CNT_W       = 8,
  parameter int ALLOW_SPACE = 1
) (
  input logic              clk,
  input logic              clr,
  expr_recognizer_if.slave bus
);

  localparam logic [3:0] MAX_DIGITS_L = 4'(MAX_DIGITS);
  localparam logic [3:0] MAX_DEPTH_L  = 4'(MAX_DEPTH);

  typedef enum logic [1:0] {
    START = 2'd0,  // expecting an operand or '('
    NUM   = 2'd1,  // inside a digit run
    AFTER = 2'd2,  // operand closed by space or ')'
    ERR   = 2'd3   // absorbing until clr
  } state_t;

  typedef enum logic [2:0] {
    C_DIG, C_OP, C_LP, C_RP, C_EQ, C_SP, C_BAD
  } sym_t;

  state_t           state_q;
  logic [3:0]       digit_cnt_q;
  logic [3:0]       depth_q;
  logic [CNT_W-1:0] cnt_q;
  logic             accept_q;

  sym_t             sym;
  logic [CNT_W-1:0] cnt_base;
  logic [CNT_W-1:0] cnt_inc;

  // Classify the incoming byte; space is only a separator when enabled.
  always_comb begin
    sym = C_BAD;
    if (bus.in >= 8'd48 && bus.in <= 8'd57) begin
      sym = C_DIG;
    end else begin
      case (bus.in)
        8'd42, 8'd43, 8'd45, 8'd47: sym = C_OP;
        8'd40:                      sym = C_LP;
        8'd41:                      sym = C_RP;
        8'd61:                      sym = C_EQ;
        8'd32:                      sym = (ALLOW_SPACE != 0) ? C_SP : C_BAD;
        default:                    sym = C_BAD;
      endcase
    end
  end

  // Next operand count: the accept cycle wipes the old count first, then saturating +1.
  always_comb begin
    cnt_base = accept_q ? '0 : cnt_q;
    cnt_inc  = (&cnt_base) ? cnt_base : cnt_base + 1'b1;
  end

  // Main recogniser FSM with registered counters and accept pulse.
  always_ff @(posedge clk) begin
    if (clr) begin
      state_q     <= START;
      digit_cnt_q <= 4'd0;
      depth_q     <= 4'd0;
      cnt_q       <= '0;
      accept_q    <= 1'b0;
    end else begin
      accept_q <= 1'b0;
      // The finished expression's count is visible for exactly the accept cycle.
      if (accept_q) cnt_q <= '0;
      if (bus.in_valid) begin
        case (state_q)
          START: begin
            case (sym)
              C_DIG: begin
                state_q     <= NUM;
                digit_cnt_q <= 4'd1;
                cnt_q       <= cnt_inc;
              end
              C_LP: begin
                if (depth_q < MAX_DEPTH_L) depth_q <= depth_q + 4'd1;
                else                       state_q <= ERR;
              end
              C_SP: begin
              end
              default: state_q <= ERR;
            endcase
          end
          NUM, AFTER: begin
            case (sym)
              C_DIG: begin
                // Digits only extend an unbroken run, never resume after space or ')'.
                if (state_q == NUM && digit_cnt_q < MAX_DIGITS_L) digit_cnt_q <= digit_cnt_q + 4'd1;
                else                                              state_q <= ERR;
              end
              C_OP: state_q <= START;
              C_RP: begin
                if (depth_q != 4'd0) begin
                  depth_q <= depth_q - 4'd1;
                  state_q <= AFTER;
                end else begin
                  state_q <= ERR;
                end
              end
              C_SP: state_q <= AFTER;
              C_EQ: begin
                if (depth_q == 4'd0) begin
                  accept_q <= 1'b1;
                  state_q  <= START;
                end else begin
                  state_q <= ERR;
                end
              end
              default: state_q <= ERR;
            endcase
          end
          default: begin
          end
        endcase
      end
    end
  end

  assign bus.out         = (state_q == NUM || state_q == AFTER) && (depth_q == 4'd0);
  assign bus.accept      = accept_q;
  assign bus.error       = (state_q == ERR);
  assign bus.depth       = depth_q;
  assign bus.operand_cnt = cnt_q;

endmodule

// File: tb/tb_expr_recognizer.sv
// tb/tb_expr_recognizer.sv - directed and randomized bench for expr_recognizer with grammar-level model
module tb_expr_recognizer;

  localparam int CNT_W = 8;
  localparam int MAXD  = 4;
  localparam int MAXP  = 7;

  logic clk = 1'b0;
  logic clr = 1'b1;
  always #5 clk = ~clk;

  expr_recognizer_if #(.CNT_W(CNT_W)) bus_a ();
  expr_recognizer_if #(.CNT_W(CNT_W)) bus_b ();

  expr_recognizer #(.MAX_DIGITS(MAXD), .MAX_DEPTH(MAXP), .CNT_W(CNT_W), .ALLOW_SPACE(1)) dut_a (
    .clk(clk), .clr(clr), .bus(bus_a)
  );
  expr_recognizer #(.MAX_DIGITS(MAXD), .MAX_DEPTH(MAXP), .CNT_W(CNT_W), .ALLOW_SPACE(0)) dut_b (
    .clk(clk), .clr(clr), .bus(bus_b)
  );

  int checks = 0;
  int errors = 0;

  // Grammar model: index 0 allows spaces, index 1 does not.
  byte unsigned m_ns[2];   // last non-space symbol of current expression, 0 = none
  byte unsigned m_raw[2];  // last symbol of current expression, 0 = none
  int           m_run[2];
  int           m_depth[2];
  int           m_cnt[2];
  bit           m_err[2];
  bit           m_acc[2];

  function automatic bit is_dig(byte unsigned b);
    return (b >= 8'd48 && b <= 8'd57);
  endfunction

  function automatic bit is_op(byte unsigned b);
    return (b == 8'd42 || b == 8'd43 || b == 8'd45 || b == 8'd47);
  endfunction

  task automatic model_step(input int i, input bit v, input byte unsigned s, input bit c);
    bit ended;
    bit fail;
    if (c) begin
      m_ns[i] = 0; m_raw[i] = 0; m_run[i] = 0; m_depth[i] = 0;
      m_cnt[i] = 0; m_err[i] = 0; m_acc[i] = 0;
      return;
    end
    if (m_acc[i]) m_cnt[i] = 0;
    m_acc[i] = 0;
    if (!v || m_err[i]) return;
    ended = is_dig(m_ns[i]) || m_ns[i] == 8'd41;
    fail  = 0;
    if (is_dig(s)) begin
      if (is_dig(m_raw[i])) begin
        if (m_run[i] < MAXD) m_run[i]++;
        else fail = 1;
      end else if (!ended) begin
        m_run[i] = 1;
        if (m_cnt[i] < 255) m_cnt[i]++;
      end else begin
        fail = 1;
      end
    end else if (is_op(s)) begin
      fail = !ended;
    end else if (s == 8'd40) begin
      if (!ended && m_depth[i] < MAXP) m_depth[i]++;
      else fail = 1;
    end else if (s == 8'd41) begin
      if (ended && m_depth[i] > 0) m_depth[i]--;
      else fail = 1;
    end else if (s == 8'd61) begin
      if (ended && m_depth[i] == 0) m_acc[i] = 1;
      else fail = 1;
    end else if (s == 8'd32) begin
      fail = (i == 1);
    end else begin
      fail = 1;
    end
    if (fail) begin
      m_err[i] = 1;
    end else if (s == 8'd61) begin
      m_ns[i] = 0;
      m_raw[i] = 0;
    end else begin
      m_raw[i] = s;
      if (s != 8'd32) m_ns[i] = s;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cmp_inst(input int i, input string nm, input logic o, input logic a, input logic e,
                          input logic [3:0] d, input logic [CNT_W-1:0] c);
    bit exp_out;
    exp_out = !m_err[i] && (is_dig(m_ns[i]) || m_ns[i] == 8'd41) && m_depth[i] == 0;
    chk({nm, "_out"}, o, exp_out);
    chk({nm, "_accept"}, a, m_acc[i]);
    chk({nm, "_error"}, e, m_err[i]);
    chk({nm, "_depth"}, d, m_depth[i]);
    chk({nm, "_cnt"}, c, m_cnt[i]);
  endtask

  task automatic cycle(input bit v, input byte unsigned s, input bit c);
    @(negedge clk);
    clr = c;
    bus_a.in_valid = v; bus_a.in = s;
    bus_b.in_valid = v; bus_b.in = s;
    @(posedge clk);
    model_step(0, v, s, c);
    model_step(1, v, s, c);
    #1;
    cmp_inst(0, "a", bus_a.out, bus_a.accept, bus_a.error, bus_a.depth, bus_a.operand_cnt);
    cmp_inst(1, "b", bus_b.out, bus_b.accept, bus_b.error, bus_b.depth, bus_b.operand_cnt);
  endtask

  task automatic feed(input string str);
    for (int k = 0; k < str.len(); k++) cycle(1'b1, str[k], 1'b0);
  endtask

  function automatic byte unsigned pick();
    int r;
    string ops;
    ops = "+-*/";
    r = $urandom_range(0, 99);
    if (r < 40) return 8'(48 + $urandom_range(0, 9));
    if (r < 60) return ops[$urandom_range(0, 3)];
    if (r < 70) return 8'd40;
    if (r < 80) return 8'd41;
    if (r < 88) return 8'd61;
    if (r < 96) return 8'd32;
    return 8'($urandom_range(0, 255));
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached, checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    string s;
    int    dseq[9];
    bus_a.in_valid = 1'b0; bus_a.in = 8'd0;
    bus_b.in_valid = 1'b0; bus_b.in = 8'd0;

    // Reset state
    cycle(1'b0, 8'd0, 1'b1);
    chk("rst_out", bus_a.out, 0);
    chk("rst_accept", bus_a.accept, 0);
    chk("rst_error", bus_a.error, 0);
    chk("rst_depth", bus_a.depth, 0);
    chk("rst_cnt", bus_a.operand_cnt, 0);

    // 1: "12+3="
    cycle(1'b1, "1", 1'b0); chk("t1_out1", bus_a.out, 1);
    cycle(1'b1, "2", 1'b0); chk("t1_out2", bus_a.out, 1);
    cycle(1'b1, "+", 1'b0); chk("t1_out3", bus_a.out, 0);
    cycle(1'b1, "3", 1'b0); chk("t1_out4", bus_a.out, 1);
    cycle(1'b1, "=", 1'b0);
    chk("t1_accept", bus_a.accept, 1);
    chk("t1_cnt", bus_a.operand_cnt, 2);
    cycle(1'b0, 8'd0, 1'b0);
    chk("t1_accept_drop", bus_a.accept, 0);
    chk("t1_cnt_clear", bus_a.operand_cnt, 0);
    chk("t1_error", bus_a.error, 0);

    // 2: digit-length boundary and sticky error
    cycle(1'b0, 8'd0, 1'b1);
    feed("1234");
    chk("t2_out", bus_a.out, 1);
    chk("t2_noerr", bus_a.error, 0);
    cycle(1'b1, "5", 1'b0);
    chk("t2_err", bus_a.error, 1);
    s = "+1=";
    for (int k = 0; k < s.len(); k++) begin
      cycle(1'b1, s[k], 1'b0);
      chk("t2_sticky", bus_a.error, 1);
      chk("t2_noacc", bus_a.accept, 0);
    end

    // 3: nested parentheses
    cycle(1'b0, 8'd0, 1'b1);
    s = "(1+(2*3))";
    dseq = '{1, 1, 1, 2, 2, 2, 2, 1, 0};
    for (int k = 0; k < 9; k++) begin
      cycle(1'b1, s[k], 1'b0);
      chk("t3_depth", bus_a.depth, dseq[k]);
      chk("t3_out", bus_a.out, (k == 8) ? 1 : 0);
    end
    cycle(1'b1, "=", 1'b0);
    chk("t3_accept", bus_a.accept, 1);
    chk("t3_cnt", bus_a.operand_cnt, 3);
    chk("t3_depth0", bus_a.depth, 0);

    // 4: depth and ')' errors
    cycle(1'b0, 8'd0, 1'b1);
    feed("1)");
    chk("t4_rp_err", bus_a.error, 1);
    cycle(1'b0, 8'd0, 1'b1);
    for (int k = 0; k < 7; k++) cycle(1'b1, "(", 1'b0);
    chk("t4_depth7", bus_a.depth, 7);
    chk("t4_noerr7", bus_a.error, 0);
    cycle(1'b1, "(", 1'b0);
    chk("t4_err8", bus_a.error, 1);
    chk("t4_depth_hold", bus_a.depth, 7);
    cycle(1'b0, 8'd0, 1'b1);
    feed("(1=");
    chk("t4_eq_err", bus_a.error, 1);

    // 5: spaces
    cycle(1'b0, 8'd0, 1'b1);
    feed("1 ");
    chk("t5_b_sp_err", bus_b.error, 1);
    chk("t5_a_sp_ok", bus_a.error, 0);
    feed("+ 2 =");
    chk("t5_accept", bus_a.accept, 1);
    chk("t5_cnt", bus_a.operand_cnt, 2);
    cycle(1'b0, 8'd0, 1'b1);
    feed("1 2");
    chk("t5_digit_after_sp", bus_a.error, 1);

    // 6: idle gaps, clr priority, recovery
    cycle(1'b0, 8'd0, 1'b1);
    s = "(1+";
    for (int k = 0; k < s.len(); k++) begin
      cycle(1'b1, s[k], 1'b0);
      for (int g = 0; g < 3; g++) begin
        cycle(1'b0, 8'hFF, 1'b0);
        chk("t6_depth_hold", bus_a.depth, 1);
        chk("t6_out_hold", bus_a.out, 0);
        chk("t6_err_hold", bus_a.error, 0);
      end
    end
    cycle(1'b1, "2", 1'b1);
    chk("t6_clr_out", bus_a.out, 0);
    chk("t6_clr_depth", bus_a.depth, 0);
    chk("t6_clr_cnt", bus_a.operand_cnt, 0);
    chk("t6_clr_err", bus_a.error, 0);
    feed("7=");
    chk("t6_accept", bus_a.accept, 1);
    chk("t6_cnt", bus_a.operand_cnt, 1);

    // Randomized traffic against the model
    cycle(1'b0, 8'd0, 1'b1);
    for (int n = 0; n < 3000; n++) begin
      if ((m_err[0] && m_err[1]) || $urandom_range(0, 299) == 0)
        cycle(1'($urandom_range(0, 1)), pick(), 1'b1);
      else
        cycle(($urandom_range(0, 4) != 0), pick(), 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/expr_recognizer.md
Name: expr_recognizer

Overview:
- Synchronous recogniser for ASCII arithmetic-expression streams, one symbol per accepted cycle.
- Generalises the single-digit "digit (op digit)*" checker:
  - multi-digit operands of bounded length;
  - four operators;
  - nested parentheses up to a bounded depth;
  - optional space skipping;
  - an '=' terminator that signals acceptance and rearms the block for the next expression.
- Sits after the byte-input stage of the string-checking datapath and drives status flags and counters to the host logic.

Parameters:
- MAX_DIGITS, 4: maximum digits per operand (1..15).
- MAX_DEPTH, 7: maximum parenthesis nesting depth (1..15).
- CNT_W, 8: width of operand counter.
- ALLOW_SPACE, 1: 1 = ASCII space (32) is a separator; 0 = space is illegal.

Ports:
- clk, input, 1: rising-edge clock, single clock domain.
- clr, input, 1: synchronous active-high reset.
- in_valid, input, 1: in carries a symbol this cycle.
- in, input, 8: ASCII symbol.
- out, output, 1: symbols consumed so far form a complete expression (combinational from registers only).
- accept, output, 1: one-cycle pulse, registered; a complete expression was terminated by '='.
- error, output, 1: sticky; illegal symbol sequence seen.
- depth, output, 4: current open-parenthesis count.
- operand_cnt, output, CNT_W: operands seen in the current expression; saturates at all-ones.

Behaviour:
- Clock and reset:
  - One clock (clk). Reset is synchronous and active-high (clr); clr is sampled only on the rising edge of clk.
  - clr has priority over in_valid in the same cycle.
  - Reset values: state=START, depth=0, operand_cnt=0, digit count=0, accept=0, error=0, out=0.
- Symbol classes:
  - DIG = 48..57.
  - OP = 42 '*', 43 '+', 45 '-', 47 '/'.
  - LP = 40. RP = 41. EQ = 61.
  - SP = 32, legal only if ALLOW_SPACE=1.
  - Any other code is ILLEGAL.
- in_valid=0: all registers hold; accept drops to 0.
- States: START (expect operand), NUM (inside operand), AFTER (operand ended, expect operator/RP/EQ), ERR.
- START transitions:
  - DIG -> NUM; digit count=1; operand_cnt+1.
  - LP: if depth<MAX_DEPTH, stay in START with depth+1; else ERR.
  - SP -> START.
  - OP, RP, EQ or ILLEGAL -> ERR.
- NUM transitions:
  - DIG: if digit count<MAX_DIGITS, stay in NUM with count+1; else ERR.
  - OP -> START.
  - RP: if depth>0, go to AFTER with depth-1; else ERR.
  - SP -> AFTER.
  - EQ: if depth==0, accept<=1 and go to START; else ERR.
  - LP or ILLEGAL -> ERR.
- AFTER transitions:
  - Same as NUM, except DIG -> ERR (no digits after a separator or ')').
- ERR: absorbing; only clr leaves it.
- Outputs:
  - error = (state==ERR).
  - out = (state==NUM or AFTER) and depth==0 and not ERR. out updates the cycle after the symbol is consumed.
- accept:
  - High exactly one cycle, the cycle after the EQ edge.
  - In the accept cycle, operand_cnt still shows the final count of the finished expression, and depth=0.
  - On the edge ending the accept cycle, operand_cnt clears to 0. If a DIG is consumed on that same edge, operand_cnt becomes 1.
- Leading zeros are legal. Unary minus is not supported: OP in START -> ERR.
- Back-to-back expressions are legal with no idle cycle between EQ and the next symbol.

Test Plan:
1. Defaults; feed "12+3=" on consecutive cycles.
   - out after each symbol: 1,1,0,1.
   - accept=1 the cycle after '=', with operand_cnt=2.
   - Next cycle: operand_cnt=0, accept=0, error=0.
2. MAX_DIGITS=4; feed "1234" -> out=1, no error. Then '5' -> error=1 the next cycle. Further "+1=" keeps error=1 and accept=0 until clr.
3. Feed "(1+(2*3))=".
   - depth sequence: 1,1,1,2,2,2,2,1,0.
   - out=1 only after the final ')'.
   - accept pulse with operand_cnt=3.
4. Depth and RP errors:
   - "1)" -> error after ')' (depth 0).
   - With MAX_DEPTH=7, eight consecutive '(' -> depth reaches 7, error on the 8th.
   - "(1=" -> error on '='.
5. Spaces:
   - ALLOW_SPACE=1: "1 + 2 =" -> accept with operand_cnt=2.
   - "1 2" -> error on '2'.
   - ALLOW_SPACE=0: "1 +" -> error on the space.
6. Control:
   - "(1+" with in_valid gaps of 3 idle cycles between symbols -> state/depth held.
   - clr asserted together with in_valid on '2' -> all outputs at reset values next cycle, symbol ignored.
   - Then "7=" -> accept, operand_cnt=1.
